// File: rtl/bcd_ascii_streamer.sv
// bcd_ascii_streamer: converts a signed binary value to decimal ASCII with a
// sequential double-dabble (one bit per clock) and streams the characters
// ('-', digits, optional CR/LF) over a registered ready/valid byte interface.
module bcd_ascii_streamer #(
    parameter int DATA_W    = 16,
    parameter int DIGITS    = 5,
    parameter bit TERMINATE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic signed [DATA_W-1:0] value_i,
    output logic                     busy_o,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic                     done_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    // Decimal digits needed for the largest magnitude, 2**(DATA_W-1).
    function automatic int min_digits(input int w);
        longint unsigned v;
        int              n;
        v = 64'd1 << (w - 1);
        n = 0;
        while (v != 0) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    if (DIGITS < min_digits(DATA_W)) begin : g_digits_check
        $error("bcd_ascii_streamer: DIGITS too small to hold 2**(DATA_W-1)");
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [BCD_W-1:0] b,
                                             input logic [IDX_W-1:0] idx);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx) r = b[i*4 +: 4];
        end
        return r;
    endfunction

    // Index of the most significant non-zero nibble; 0 when all nibbles are zero.
    function automatic logic [IDX_W-1:0] ms_nonzero(input logic [BCD_W-1:0] b);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[i*4 +: 4] != 4'd0) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    typedef enum logic [2:0] {
        S_IDLE, S_CONVERT, S_SIGN, S_DIGIT, S_CR, S_LF
    } state_t;

    state_t            state_q, state_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              sign_q, sign_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic [DATA_W-1:0] value_u;
    logic [DATA_W-1:0] mag_abs;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_shift;
    logic [7:0]        first_byte;
    logic [7:0]        cur_byte;
    logic              xfer;
    logic              last_byte;
    logic              conv_last;

    // The most negative input yields 2**(DATA_W-1), which fits unsigned DATA_W bits.
    assign value_u   = value_i;
    assign mag_abs   = value_u[DATA_W-1] ? (~value_u + DATA_W'(1)) : value_u;

    assign bcd_adj   = dabble_adjust(bcd_q);
    assign bcd_shift = {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
    assign conv_last = (state_q == S_CONVERT) && (cnt_q == '0);

    // The first byte is built from the final BCD result on the last convert
    // cycle so tx_valid_o can rise right as conversion ends.
    assign first_byte = sign_q ? CH_MINUS
                               : ascii_digit(nibble_at(bcd_shift, ms_nonzero(bcd_shift)));

    assign xfer      = tx_valid_q & tx_ready_i;
    assign last_byte = TERMINATE ? (state_q == S_LF)
                                 : ((state_q == S_DIGIT) && (idx_q == '0));

    assign busy_o     = (state_q != S_IDLE);
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign done_o     = xfer & last_byte;

    // Character presented by each emitting state.
    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            S_SIGN:  cur_byte = CH_MINUS;
            S_DIGIT: cur_byte = ascii_digit(nibble_at(bcd_q, idx_q));
            S_CR:    cur_byte = CH_CR;
            S_LF:    cur_byte = CH_LF;
            default: cur_byte = 8'h00;
        endcase
    end

    // State register plus the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Next-state logic: each emitting state advances only on a transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_CONVERT;
            S_CONVERT: if (cnt_q == '0) state_d = sign_q ? S_SIGN : S_DIGIT;
            S_SIGN:    if (xfer) state_d = S_DIGIT;
            S_DIGIT:   if (xfer && (idx_q == '0)) state_d = TERMINATE ? S_CR : S_IDLE;
            S_CR:      if (xfer) state_d = S_LF;
            S_LF:      if (xfer) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic: valid drops for one cycle after each transfer, then the
    // next state's byte is loaded; a stalled byte is held untouched.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: tx_valid_d = 1'b0;
            S_CONVERT: begin
                if (conv_last) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = first_byte;
                end
            end
            default: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                end else if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = cur_byte;
                end
            end
        endcase
    end

    // Conversion datapath registers: magnitude, BCD, bit counter, digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            mag_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            mag_q  <= mag_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sign_q <= sign_d;
        end
    end

    // Datapath next-state: capture on start, dabble while converting, walk digits down.
    always_comb begin
        bcd_d  = bcd_q;
        mag_d  = mag_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        sign_d = sign_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sign_d = value_u[DATA_W-1];
                    mag_d  = mag_abs;
                    bcd_d  = '0;
                    cnt_d  = CNT_W'(DATA_W - 1);
                    idx_d  = '0;
                end
            end
            S_CONVERT: begin
                bcd_d = bcd_shift;
                mag_d = mag_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) idx_d = ms_nonzero(bcd_shift);
            end
            S_DIGIT: begin
                if (xfer && (idx_q != '0)) idx_d = idx_q - IDX_W'(1);
            end
            default: ;
        endcase
    end

endmodule
